decoder_scheduler: RTL and testbench

Front-end scheduler for the turbo `Decoder` core. It arbitrates round-robin between `NUM_REQ` requesters, each presenting one 84-bit coded frame. It serialises the granted frame into the Decoder's 21-bit start/data load sequence, then waits for `done_o` with a timeout. It returns the 5-bit decoded result, tagged with the requester ID. It sits between the frame sources and a single `Decoder` instance, and is the only block that drives that instance's `start_i`/`data_i`.

---
 rtl/decoder_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_decoder_scheduler.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_scheduler.sv
// Front-end scheduler for the turbo Decoder core.
// Picks one of NUM_REQ requesters round-robin, streams its 84-bit frame into
// the Decoder as four 21-bit words plus a tail cycle, then waits for done
// (bounded by TIMEOUT) and returns the 5-bit result tagged with the requester.
module decoder_scheduler #(
   parameter int NUM_REQ = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                   clk_p_i,
   input  logic                   reset_p_i,
   input  logic [NUM_REQ-1:0]     req_i,
   input  logic [NUM_REQ*84-1:0]  frame_i,
   output logic [NUM_REQ-1:0]     gnt_o,
   output logic                   busy_o,
   output logic                   rsp_valid_o,
   output logic [1:0]             rsp_id_o,
   output logic [4:0]             rsp_data_o,
   output logic                   rsp_err_o,
   output logic                   dec_start_o,
   output logic [20:0]            dec_data_o,
   input  logic [4:0]             dec_data_i,
   input  logic                   dec_done_i
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_TAIL, S_WAIT} state_t;

   localparam int CNT_W = 10;

   state_t             state_q, state_d;
   logic [1:0]         word_q, word_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         ptr_q, ptr_d;
   logic [1:0]         id_q, id_d;
   logic [83:0]        frame_q, frame_d;

   logic [NUM_REQ-1:0] gnt_d;
   logic               busy_d, rsp_valid_d, rsp_err_d, dec_start_d;
   logic [1:0]         rsp_id_d;
   logic [4:0]         rsp_data_d;
   logic [20:0]        dec_data_d;

   // Requests and frames padded to four slots so a 2-bit index always fits.
   logic [3:0]         req_arr;
   logic [83:0]        frame_arr [4];
   logic [20:0]        word_arr [4];

   logic [2:0]         slot;
   logic [1:0]         pick;
   logic               pick_vld;

   for (genvar k = 0; k < 4; k++) begin : g_slot
      if (k < NUM_REQ) begin : g_used
         assign req_arr[k]   = req_i[k];
         assign frame_arr[k] = frame_i[k*84 +: 84];
      end else begin : g_unused
         assign req_arr[k]   = 1'b0;
         assign frame_arr[k] = '0;
      end
      assign word_arr[k] = frame_q[k*21 +: 21];
   end

   // Round-robin pick: first pending requester at or after the pointer, wrapping.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
      slot     = '0;
      pick     = '0;
      pick_vld = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         slot = {1'b0, ptr_q} + 3'(i);
         if (slot >= 3'(NUM_REQ)) slot = slot - 3'(NUM_REQ);
         if (!pick_vld && req_arr[slot[1:0]]) begin
            pick_vld = 1'b1;
            pick     = slot[1:0];
         end
      end
   end

   // Next-state and next-output logic; every output is registered from these.
   always_comb begin
      state_d     = state_q;
      word_d      = word_q;
      cnt_d       = cnt_q;
      ptr_d       = ptr_q;
      id_d        = id_q;
      frame_d     = frame_q;
      gnt_d       = '0;
      rsp_valid_d = 1'b0;
      rsp_id_d    = rsp_id_o;
      rsp_data_d  = rsp_data_o;
      rsp_err_d   = rsp_err_o;
      dec_data_d  = dec_data_o;

      unique case (state_q)
         S_IDLE: begin
            if (pick_vld) begin
               state_d    = S_LOAD;
               word_d     = '0;
               frame_d    = frame_arr[pick];
               id_d       = pick;
               ptr_d      = (pick == 2'(NUM_REQ-1)) ? 2'd0 : pick + 2'd1;
               gnt_d      = NUM_REQ'(1) << pick;
               dec_data_d = frame_arr[pick][20:0];
            end
         end
         S_LOAD: begin
            if (word_q == 2'd3) begin
               state_d = S_TAIL;
            end else begin
               word_d     = word_q + 2'd1;
               dec_data_d = word_arr[word_q + 2'd1];
            end
         end
         S_TAIL: begin
            state_d = S_WAIT;
            cnt_d   = '0;
         end
         S_WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            // Done takes priority over a timeout landing on the same cycle.
            if (dec_done_i) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b1;
               rsp_id_d    = id_q;
               rsp_data_d  = dec_data_i;
               rsp_err_d   = 1'b0;
            end else if (cnt_q == CNT_W'(TIMEOUT-1)) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b1;
               rsp_id_d    = id_q;
               rsp_data_d  = '0;
               rsp_err_d   = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d      = (state_d != S_IDLE);
      dec_start_d = (state_d == S_LOAD) || (state_d == S_TAIL);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_p_i) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      if (reset_p_i) begin
         state_q     <= S_IDLE;
         word_q      <= '0;
         cnt_q       <= '0;
         ptr_q       <= '0;
         id_q        <= '0;
         gnt_o       <= '0;
         busy_o      <= 1'b0;
         rsp_valid_o <= 1'b0;
         rsp_id_o    <= '0;
         rsp_data_o  <= '0;
         rsp_err_o   <= 1'b0;
         dec_start_o <= 1'b0;
         dec_data_o  <= '0;
      end else begin
         state_q     <= state_d;
         word_q      <= word_d;
         cnt_q       <= cnt_d;
         ptr_q       <= ptr_d;
         id_q        <= id_d;
         gnt_o       <= gnt_d;
         busy_o      <= busy_d;
         rsp_valid_o <= rsp_valid_d;
         rsp_id_o    <= rsp_id_d;
         rsp_data_o  <= rsp_data_d;
         rsp_err_o   <= rsp_err_d;
         dec_start_o <= dec_start_d;
         dec_data_o  <= dec_data_d;
      end
   end

   // Latched frame payload.
   always_ff @(posedge clk_p_i) begin
      // NOTE: the payload register is not reset; it is always reloaded at grant before anything reads it.
      frame_q <= frame_d;
   end

endmodule

// File: tb/tb_decoder_scheduler.sv
// Self-checking bench for decoder_scheduler. Two instances share stimulus:
// u_dut uses the default TIMEOUT, u_dut_short uses TIMEOUT=8 for the
// timeout and collision scenarios. Expected behaviour comes from a small
// job-level model (round-robin pointer, word slicing, done/timeout arithmetic).
module tb_decoder_scheduler;

   localparam int NUM_REQ  = 2;
   localparam int TO_MAIN  = 64;
   localparam int TO_SHORT = 8;

   logic         clk, rst;
   logic [1:0]   req;
   logic [83:0]  frm [2];
   logic [167:0] frame;
   logic [4:0]   ddata;
   logic         ddone;

   assign frame = {frm[1], frm[0]};

   logic [1:0]  m_gnt, t_gnt, m_id, t_id;
   logic        m_busy, t_busy, m_rv, t_rv, m_err, t_err, m_st, t_st;
   logic [4:0]  m_rd, t_rd;
   logic [20:0] m_dd, t_dd;

   decoder_scheduler #(.NUM_REQ(NUM_REQ), .TIMEOUT(TO_MAIN)) u_dut (
      .clk_p_i(clk), .reset_p_i(rst), .req_i(req), .frame_i(frame),
      .gnt_o(m_gnt), .busy_o(m_busy), .rsp_valid_o(m_rv), .rsp_id_o(m_id),
      .rsp_data_o(m_rd), .rsp_err_o(m_err), .dec_start_o(m_st), .dec_data_o(m_dd),
      .dec_data_i(ddata), .dec_done_i(ddone));

   decoder_scheduler #(.NUM_REQ(NUM_REQ), .TIMEOUT(TO_SHORT)) u_dut_short (
      .clk_p_i(clk), .reset_p_i(rst), .req_i(req), .frame_i(frame),
      .gnt_o(t_gnt), .busy_o(t_busy), .rsp_valid_o(t_rv), .rsp_id_o(t_id),
      .rsp_data_o(t_rd), .rsp_err_o(t_err), .dec_start_o(t_st), .dec_data_o(t_dd),
      .dec_data_i(ddata), .dec_done_i(ddone));

   // Observed outputs of whichever instance the current scenario targets.
   bit          sel_to;
   logic [1:0]  o_gnt, o_id;
   logic        o_busy, o_rv, o_err, o_start;
   logic [4:0]  o_rd;
   logic [20:0] o_ddata;
   assign o_gnt   = sel_to ? t_gnt  : m_gnt;
   assign o_id    = sel_to ? t_id   : m_id;
   assign o_busy  = sel_to ? t_busy : m_busy;
   assign o_rv    = sel_to ? t_rv   : m_rv;
   assign o_err   = sel_to ? t_err  : m_err;
   assign o_start = sel_to ? t_st   : m_st;
   assign o_rd    = sel_to ? t_rd   : m_rd;
   assign o_ddata = sel_to ? t_dd   : m_dd;

   int         checks;
   int         failures;
   int         mdl_ptr;
   logic [1:0] last_id;
   logic [4:0] last_data;
   logic       last_err;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, want finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      req   = 2'b00;
      ddone = 1'b0;
      ddata = '0;
      step();
      step();
      rst       = 1'b0;
      mdl_ptr   = 0;
      last_id   = '0;
      last_data = '0;
      last_err  = 1'b0;
   endtask

   task automatic rand_frames();
      for (int k = 0; k < NUM_REQ; k++)
         frm[k] = 84'({$urandom(), $urandom(), $urandom()});
   endtask

   // One complete job starting from IDLE with req already presented this cycle.
   // done_at: WAIT-cycle index (0 = first WAIT cycle) at which done is driven, -1 for never.
   task automatic run_job(input int done_at, input bit stray, input bit rearm,
                          input logic [4:0] res, input string tag, output int gnt_seen);
      int          g, to, e;
      bit          ok;
      logic [83:0] f;
      logic [20:0] wd;
      logic [1:0]  eg;
      logic [4:0]  exp_data;
      to = sel_to ? TO_SHORT : TO_MAIN;
      g  = -1;
      for (int i = 0; i < NUM_REQ; i++) begin
         int k;
         k = (mdl_ptr + i) % NUM_REQ;
         if (g < 0 && ((req >> k) & 2'b01) == 2'b01) g = k;
      end
      gnt_seen = -1;
      if (g < 0) begin
         checks++;
         failures++;
         $display("FAIL %s pick: got no pending request, want at least one", tag);
         return;
      end
      f        = frm[g];
      mdl_ptr  = (g + 1) % NUM_REQ;
      eg       = 2'(1 << g);
      ok       = (done_at >= 0) && (done_at <= to - 1);
      e        = ok ? done_at : to - 1;
      exp_data = ok ? res : 5'd0;

      step();  // T+1: grant, word 0
      gnt_seen = (o_gnt == 2'b01) ? 0 : (o_gnt == 2'b10) ? 1 : -1;
      checks++;
      if ({o_gnt, o_busy, o_start, o_ddata} !== {eg, 1'b1, 1'b1, f[20:0]}) begin
         failures++;
         $display("FAIL %s grant: got gnt=%b busy=%b start=%b data=%h, want gnt=%b busy=1 start=1 data=%h",
                  tag, o_gnt, o_busy, o_start, o_ddata, eg, f[20:0]);
      end
      checks++;
      if ({o_rv, o_id, o_rd, o_err} !== {1'b0, last_id, last_data, last_err}) begin
         failures++;
         $display("FAIL %s rsp_hold: got valid=%b id=%0d data=%h err=%b, want valid=0 id=%0d data=%h err=%b",
                  tag, o_rv, o_id, o_rd, o_err, last_id, last_data, last_err);
      end
      req = req & ~eg;
      if (stray) begin
         ddone = 1'b1;
         ddata = ~res;
      end

      for (int w = 1; w <= 4; w++) begin  // words 1..3, then TAIL holding word 3
         step();
         ddone = 1'b0;
         if (rearm && w == 1) req = req | eg;
         wd = 21'(f >> (21 * ((w == 4) ? 3 : w)));
         checks++;
         if ({o_gnt, o_busy, o_start, o_rv, o_ddata} !== {2'b00, 1'b1, 1'b1, 1'b0, wd}) begin
            failures++;
            $display("FAIL %s load%0d: got gnt=%b busy=%b start=%b valid=%b data=%h, want gnt=00 busy=1 start=1 valid=0 data=%h",
                     tag, w, o_gnt, o_busy, o_start, o_rv, o_ddata, wd);
         end
      end

      step();  // T+6: first WAIT cycle
      for (int k = 0; k <= e; k++) begin
         checks++;
         if ({o_busy, o_start, o_rv, o_ddata} !== {1'b1, 1'b0, 1'b0, wd}) begin
            failures++;
            $display("FAIL %s wait%0d: got busy=%b start=%b valid=%b data=%h, want busy=1 start=0 valid=0 data=%h",
                     tag, k, o_busy, o_start, o_rv, o_ddata, wd);
         end
         if (k == done_at) begin
            ddone = 1'b1;
            ddata = res;
         end
         step();
         ddone = 1'b0;
      end

      checks++;
      if ({o_rv, o_id, o_rd, o_err, o_busy, o_start} !== {1'b1, 2'(g), exp_data, ~ok, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL %s response: got valid=%b id=%0d data=%h err=%b busy=%b start=%b, want valid=1 id=%0d data=%h err=%b busy=0 start=0",
                  tag, o_rv, o_id, o_rd, o_err, o_busy, o_start, g, exp_data, ~ok);
      end
      last_id   = 2'(g);
      last_data = exp_data;
      last_err  = ~ok;
   endtask

   task automatic test_reset();
      sel_to = 1'b0;
      do_reset();
      checks++;
      if ({m_gnt, m_busy, m_rv, m_id, m_rd, m_err, m_st, m_dd} !== 35'd0) begin
         failures++;
         $display("FAIL reset_main: got gnt=%b busy=%b valid=%b id=%0d data=%h err=%b start=%b ddata=%h, want all zero",
                  m_gnt, m_busy, m_rv, m_id, m_rd, m_err, m_st, m_dd);
      end
      checks++;
      if ({t_gnt, t_busy, t_rv, t_id, t_rd, t_err, t_st, t_dd} !== 35'd0) begin
         failures++;
         $display("FAIL reset_short: got gnt=%b busy=%b valid=%b id=%0d data=%h err=%b start=%b ddata=%h, want all zero",
                  t_gnt, t_busy, t_rv, t_id, t_rd, t_err, t_st, t_dd);
      end
      ddone = 1'b1;  // done while idle must not produce anything
      for (int c = 0; c < 3; c++) begin
         step();
         checks++;
         if ({m_busy, m_rv, m_gnt} !== 4'b0000) begin
            failures++;
            $display("FAIL idle%0d: got busy=%b valid=%b gnt=%b, want busy=0 valid=0 gnt=00", c, m_busy, m_rv, m_gnt);
         end
      end
      ddone = 1'b0;
   endtask

   task automatic test_single();
      int gs;
      sel_to = 1'b0;
      do_reset();
      frm[0] = {21'h0AAAAA, 21'h155555, 21'h000001, 21'h1ABCD};
      frm[1] = '0;
      req    = 2'b01;
      run_job(9, 1'b0, 1'b0, 5'h13, "single", gs);
      step();
      checks++;
      if ({o_rv, o_id, o_rd, o_err} !== {1'b0, 2'd0, 5'h13, 1'b0}) begin
         failures++;
         $display("FAIL single_after: got valid=%b id=%0d data=%h err=%b, want valid=0 id=0 data=13 err=0",
                  o_rv, o_id, o_rd, o_err);
      end
   endtask

   // Both requesters held; responses back-to-back with the next grant.
   task automatic test_round_robin();
      int gs;
      sel_to = 1'b0;
      do_reset();
      rand_frames();
      req = 2'b11;
      for (int j = 0; j < 4; j++) begin
         run_job(int'($urandom_range(0, 6)), 1'b0, 1'b1, 5'($urandom()), "rr", gs);
         checks++;
         if (gs !== (j % 2)) begin
            failures++;
            $display("FAIL rr_order%0d: got grant=%0d, want %0d", j, gs, j % 2);
         end
      end
      req = 2'b00;
   endtask

   task automatic test_timeout();
      int gs;
      sel_to = 1'b1;
      do_reset();
      rand_frames();
      req = 2'b01;
      run_job(-1, 1'b0, 1'b0, 5'h1F, "timeout", gs);
      req = 2'b10;
      run_job(3, 1'b0, 1'b0, 5'($urandom()), "after_timeout", gs);
      sel_to = 1'b0;
   endtask

   task automatic test_collision_stray();
      int gs;
      sel_to = 1'b1;
      do_reset();
      rand_frames();
      req = 2'b01;
      run_job(TO_SHORT - 1, 1'b0, 1'b0, 5'h0B, "collision", gs);
      sel_to = 1'b0;
      do_reset();
      rand_frames();
      req = 2'b10;
      run_job(int'($urandom_range(2, 8)), 1'b1, 1'b0, 5'($urandom()), "stray", gs);
   endtask

   task automatic test_mid_reset();
      int gs;
      sel_to = 1'b0;
      do_reset();
      rand_frames();
      req = 2'b01;
      step();  // LOAD w=0
      checks++;
      if ({m_gnt, m_st} !== 3'b011) begin
         failures++;
         $display("FAIL midrst_grant: got gnt=%b start=%b, want gnt=01 start=1", m_gnt, m_st);
      end
      req = 2'b00;
      step();  // w=1
      step();  // w=2
      rst = 1'b1;
      step();
      checks++;
      if ({m_gnt, m_busy, m_rv, m_id, m_rd, m_err, m_st, m_dd} !== 35'd0) begin
         failures++;
         $display("FAIL midrst_zero: got gnt=%b busy=%b valid=%b id=%0d data=%h err=%b start=%b ddata=%h, want all zero",
                  m_gnt, m_busy, m_rv, m_id, m_rd, m_err, m_st, m_dd);
      end
      rst       = 1'b0;
      mdl_ptr   = 0;
      last_id   = '0;
      last_data = '0;
      last_err  = 1'b0;
      for (int c = 0; c < 20; c++) begin
         ddone = (c >= 3 && c <= 5);
         ddata = 5'($urandom());
         step();
         checks++;
         if ({m_rv, m_busy} !== 2'b00) begin
            failures++;
            $display("FAIL midrst_quiet%0d: got valid=%b busy=%b, want valid=0 busy=0", c, m_rv, m_busy);
         end
      end
      ddone = 1'b0;
      req   = 2'b11;
      run_job(4, 1'b0, 1'b0, 5'($urandom()), "post_reset", gs);
      checks++;
      if (gs !== 0) begin
         failures++;
         $display("FAIL post_reset_first: got grant=%0d, want 0", gs);
      end
      req = 2'b00;
   endtask

   // Random arrivals; ungranted requesters stay pending across jobs.
   task automatic test_random();
      int gs;
      sel_to = 1'b0;
      do_reset();
      for (int j = 0; j < 10; j++) begin
         for (int k = 0; k < NUM_REQ; k++)
            if (((req >> k) & 2'b01) == 2'b00) frm[k] = 84'({$urandom(), $urandom(), $urandom()});
         req = req | 2'($urandom_range(0, 3));
         if (req == 2'b00) req = 2'b01;
         run_job(int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), 1'b0, 5'($urandom()), "random", gs);
      end
      req = 2'b00;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      sel_to   = 1'b0;
      rst      = 1'b1;
      req      = 2'b00;
      ddone    = 1'b0;
      ddata    = '0;
      frm[0]   = '0;
      frm[1]   = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_collision_stray();
      test_mid_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
